axi_cmd_arbiter: RTL and testbench



---
 rtl/axi_cmd_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_axi_cmd_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_arbiter.sv
// rtl/axi_cmd_arbiter.sv - two-requester round-robin command arbiter/sequencer for AXI_top_design
module axi_cmd_arbiter #(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 3,
    parameter int TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0]                    req_write,
    input  logic [2*WIDTH-1:0]            req_addr,
    input  logic [2*(WIDTH/8)-1:0]        req_len,
    input  logic [2*SIZE-1:0]             req_size,
    input  logic [2*(SIZE-1)-1:0]         req_burst,
    input  logic [2*(WIDTH/8-1)-1:0]      req_id,
    output logic [1:0]                    rsp_valid,
    input  logic [1:0]                    rsp_ready,
    output logic [SIZE-2:0]               rsp_resp,
    output logic [WIDTH-1:0]              awaddr,
    output logic [WIDTH/8-1:0]            awlen,
    output logic [SIZE-1:0]               awsize,
    output logic [SIZE-2:0]               awburst,
    output logic [WIDTH/8-1:0]            awid,
    output logic [WIDTH-1:0]              araddr,
    output logic [WIDTH/8-1:0]            arlen,
    output logic [SIZE-1:0]               arsize,
    output logic [SIZE-2:0]               arburst,
    output logic [WIDTH/8-1:0]            arid,
    output logic                          wr_start,
    output logic                          rd_start,
    input  logic                          wr_done,
    input  logic [SIZE-2:0]               wr_resp,
    input  logic                          rd_done,
    input  logic [SIZE-2:0]               rd_resp,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int IW = WIDTH / 8;
    localparam int BW = SIZE - 1;
    localparam logic [BW-1:0] RESP_SLVERR = BW'(2);
    localparam logic [15:0]   CNT_LIMIT   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;
    logic            owner_q, owner_d;
    logic            kind_q, kind_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [BW-1:0]   rsp_resp_q, rsp_resp_d;
    logic            wr_start_q, wr_start_d;
    logic            rd_start_q, rd_start_d;
    logic [WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [IW-1:0]   awlen_q, awlen_d, arlen_q, arlen_d;
    logic [SIZE-1:0] awsize_q, awsize_d, arsize_q, arsize_d;
    logic [BW-1:0]   awburst_q, awburst_d, arburst_q, arburst_d;
    logic [IW-1:0]   awid_q, awid_d, arid_q, arid_d;

    logic            any_valid, winner, match_done, limit_hit;
    logic            sel_write;
    logic [WIDTH-1:0] sel_addr;
    logic [IW-1:0]   sel_len;
    logic [SIZE-1:0] sel_size;
    logic [BW-1:0]   sel_burst;
    logic [IW-2:0]   sel_id;

    // A lone requester always wins; the pointer only breaks ties.
    assign any_valid = |req_valid;
    assign winner    = (&req_valid) ? prio_q : req_valid[1];
    assign req_ready = (state_q == S_IDLE) ? (req_valid & (winner ? 2'b10 : 2'b01)) : 2'b00;

    assign sel_write = winner ? req_write[1] : req_write[0];
    assign sel_addr  = winner ? req_addr[2*WIDTH-1:WIDTH] : req_addr[WIDTH-1:0];
    assign sel_len   = winner ? req_len[2*IW-1:IW] : req_len[IW-1:0];
    assign sel_size  = winner ? req_size[2*SIZE-1:SIZE] : req_size[SIZE-1:0];
    assign sel_burst = winner ? req_burst[2*BW-1:BW] : req_burst[BW-1:0];
    assign sel_id    = winner ? req_id[2*(IW-1)-1:IW-1] : req_id[IW-2:0];

    assign match_done  = kind_q ? wr_done : rd_done;
    assign limit_hit   = (cnt_q == CNT_LIMIT);
    // A matching done in the limit cycle takes precedence over the watchdog.
    assign timeout_err = (state_q == S_WAIT) && !match_done && limit_hit;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_resp_d  = rsp_resp_q;
        wr_start_d  = 1'b0;
        rd_start_d  = 1'b0;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        awid_d      = awid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        arburst_d   = arburst_q;
        arid_d      = arid_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    owner_d = winner;
                    kind_d  = sel_write;
                    if (sel_write) begin
                        awaddr_d   = sel_addr;
                        awlen_d    = sel_len;
                        awsize_d   = sel_size;
                        awburst_d  = sel_burst;
                        awid_d     = {winner, sel_id};
                        wr_start_d = 1'b1;
                    end else begin
                        araddr_d   = sel_addr;
                        arlen_d    = sel_len;
                        arsize_d   = sel_size;
                        arburst_d  = sel_burst;
                        arid_d     = {winner, sel_id};
                        rd_start_d = 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (match_done || limit_hit) begin
                    rsp_resp_d  = match_done ? (kind_q ? wr_resp : rd_resp) : RESP_SLVERR;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    prio_d      = ~owner_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            kind_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_resp_q  <= '0;
            wr_start_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            awid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            arburst_q   <= '0;
            arid_q      <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_resp_q  <= rsp_resp_d;
            wr_start_q  <= wr_start_d;
            rd_start_q  <= rd_start_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            awid_q      <= awid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            arburst_q   <= arburst_d;
            arid_q      <= arid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = rsp_resp_q;
    assign wr_start  = wr_start_q;
    assign rd_start  = rd_start_q;
    assign busy      = (state_q != S_IDLE);
    assign awaddr    = awaddr_q;
    assign awlen     = awlen_q;
    assign awsize    = awsize_q;
    assign awburst   = awburst_q;
    assign awid      = awid_q;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arsize    = arsize_q;
    assign arburst   = arburst_q;
    assign arid      = arid_q;
endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// tb/tb_axi_cmd_arbiter.sv - directed and randomized checks of axi_cmd_arbiter against a transaction-level model
module tb_axi_cmd_arbiter;
    localparam int WIDTH = 32;
    localparam int SIZE  = 3;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, req_write = '0;
    logic [63:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [5:0]  req_size = '0;
    logic [3:0]  req_burst = '0;
    logic [5:0]  req_id = '0;
    logic [1:0]  rsp_valid, rsp_ready = '0, rsp_resp;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awlen, arlen, awid, arid;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        wr_start, rd_start, busy, timeout_err;
    logic        wr_done = 1'b0, rd_done = 1'b0;
    logic [1:0]  wr_resp = '0, rd_resp = '0;

    axi_cmd_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_burst(req_burst), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .wr_start(wr_start), .rd_start(rd_start),
        .wr_done(wr_done), .wr_resp(wr_resp), .rd_done(rd_done), .rd_resp(rd_resp),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int prio_m = 0;
    int grant_log[$];

    logic        m_write[2];
    logic [31:0] m_addr[2];
    logic [3:0]  m_len[2];
    logic [2:0]  m_size[2];
    logic [1:0]  m_burst[2];
    logic [2:0]  m_id[2];

    logic [31:0] e_awaddr = '0, e_araddr = '0;
    logic [3:0]  e_awlen = '0, e_arlen = '0, e_awid = '0, e_arid = '0;
    logic [2:0]  e_awsize = '0, e_arsize = '0;
    logic [1:0]  e_awburst = '0, e_arburst = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] s, input logic [1:0] b, input logic [2:0] id);
        m_write[i] = wr; m_addr[i] = a; m_len[i] = l; m_size[i] = s; m_burst[i] = b; m_id[i] = id;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), 2'($urandom), 3'($urandom));
    endtask

    task automatic drive_reqs(input logic [1:0] vld);
        req_valid = vld;
        req_write = {m_write[1], m_write[0]};
        req_addr  = {m_addr[1], m_addr[0]};
        req_len   = {m_len[1], m_len[0]};
        req_size  = {m_size[1], m_size[0]};
        req_burst = {m_burst[1], m_burst[0]};
        req_id    = {m_id[1], m_id[0]};
    endtask

    task automatic check_cmds();
        check("awaddr", 64'(awaddr), 64'(e_awaddr));
        check("awlen", 64'(awlen), 64'(e_awlen));
        check("awsize", 64'(awsize), 64'(e_awsize));
        check("awburst", 64'(awburst), 64'(e_awburst));
        check("awid", 64'(awid), 64'(e_awid));
        check("araddr", 64'(araddr), 64'(e_araddr));
        check("arlen", 64'(arlen), 64'(e_arlen));
        check("arsize", 64'(arsize), 64'(e_arsize));
        check("arburst", 64'(arburst), 64'(e_arburst));
        check("arid", 64'(arid), 64'(e_arid));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 64'({wr_start, rd_start}), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_resp"}, 64'(rsp_resp), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check_cmds();
    endtask

    // d = cycles from the start strobe to the matching done (0 = never); called in an IDLE cycle.
    task automatic run_txn(input logic [1:0] vld, input int d, input logic [1:0] dresp,
                           input int hold, input bit noise);
        int w;
        logic wr, match, exp_to, got;
        logic [1:0] exp_resp, own;
        int c;
        w   = (vld == 2'b11) ? prio_m : (vld[1] ? 1 : 0);
        own = (w == 1) ? 2'b10 : 2'b01;
        wr  = m_write[w];
        grant_log.push_back(w);
        drive_reqs(vld);
        wr_done = noise & 1'($urandom);
        rd_done = noise & 1'($urandom);
        #1;
        check("req_ready_accept", 64'(req_ready), 64'(own));
        check("busy_idle", 64'(busy), 64'(0));
        if (wr) begin
            e_awaddr = m_addr[w]; e_awlen = m_len[w]; e_awsize = m_size[w];
            e_awburst = m_burst[w]; e_awid = {own[1], m_id[w]};
        end else begin
            e_araddr = m_addr[w]; e_arlen = m_len[w]; e_arsize = m_size[w];
            e_arburst = m_burst[w]; e_arid = {own[1], m_id[w]};
        end
        tick();
        wr_done = noise & 1'($urandom);
        rd_done = noise & 1'($urandom);
        #1;
        check("wr_start_issue", 64'(wr_start), 64'(wr));
        check("rd_start_issue", 64'(rd_start), 64'(!wr));
        check("req_ready_issue", 64'(req_ready), 64'(0));
        check("busy_issue", 64'(busy), 64'(1));
        check_cmds();
        tick();
        got = 1'b0;
        c = 2;
        while (!got && c <= 1 + TO) begin
            match = (d > 0) && (c == 1 + d);
            if (wr) begin
                wr_done = match; wr_resp = match ? dresp : 2'($urandom);
                rd_done = noise & 1'($urandom); rd_resp = 2'($urandom);
            end else begin
                rd_done = match; rd_resp = match ? dresp : 2'($urandom);
                wr_done = noise & 1'($urandom); wr_resp = 2'($urandom);
            end
            #1;
            exp_to = (c == 1 + TO) && !match;
            check("timeout_err", 64'(timeout_err), 64'(exp_to));
            check("strobes_wait", 64'({wr_start, rd_start}), 64'(0));
            check("rsp_valid_wait", 64'(rsp_valid), 64'(0));
            if (match) begin got = 1'b1; exp_resp = dresp; end
            else if (exp_to) begin got = 1'b1; exp_resp = 2'b10; end
            tick();
            c++;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $error("FAIL wait_bound: observed no completion expected completion by cycle %0d", 1 + TO);
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~own;
            wr_done = noise & 1'($urandom);
            rd_done = noise & 1'($urandom);
            #1;
            check("rsp_valid_hold", 64'(rsp_valid), 64'(own));
            check("rsp_resp_hold", 64'(rsp_resp), 64'(exp_resp));
            check("busy_hold", 64'(busy), 64'(1));
            check("req_ready_hold", 64'(req_ready), 64'(0));
            check("timeout_err_hold", 64'(timeout_err), 64'(0));
            tick();
        end
        rsp_ready = own;
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(own));
        check("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
        check("req_ready_resp", 64'(req_ready), 64'(0));
        tick();
        rsp_ready = 2'b00;
        wr_done = 1'b0;
        rd_done = 1'b0;
        check("rsp_valid_after", 64'(rsp_valid), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        prio_m = 1 - w;
    endtask

    initial begin
        logic [1:0] vld;
        int sel, d;
        #3;
        check_all_zero("reset");
        tick();
        resetn = 1'b1;
        tick();
        check("idle_no_valid_ready", 64'(req_ready), 64'(0));

        // Both valid from reset: grants alternate 0,1,0,1 with both held valid.
        set_req(0, 1'b0, 32'h0000_2000, 4'd7, 3'd2, 2'd1, 3'd3);
        set_req(1, 1'b0, 32'h0000_3000, 4'd1, 3'd3, 2'd2, 3'd6);
        grant_log.delete();
        for (int i = 0; i < 4; i++) run_txn(2'b11, 2, 2'b00, 0, 1'b0);
        check("grant_order", 64'({grant_log[0][1:0], grant_log[1][1:0], grant_log[2][1:0], grant_log[3][1:0]}),
              64'(8'b00_01_00_01));
        check("arid_r1", 64'(arid), 64'(4'b1110));

        // Single write: done at cycle 6, response at cycle 7.
        set_req(0, 1'b1, 32'h0000_0100, 4'd3, 3'd2, 2'd1, 3'd5);
        run_txn(2'b01, 5, 2'b00, 0, 1'b0);
        check("awid_single", 64'(awid), 64'(4'b0101));

        // Read that never completes: watchdog with wrong-kind noise.
        set_req(0, 1'b0, 32'h0000_0400, 4'd2, 3'd1, 2'd0, 3'd1);
        run_txn(2'b01, 0, 2'b00, 0, 1'b1);
        // Read done landing exactly on the limit cycle.
        run_txn(2'b01, TO, 2'b01, 0, 1'b1);
        // Response backpressure.
        set_req(1, 1'b1, 32'h0000_0800, 4'd4, 3'd2, 2'd1, 3'd2);
        run_txn(2'b10, 3, 2'b11, 5, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rand_req(0);
            rand_req(1);
            vld = 2'($urandom_range(1, 3));
            sel = $urandom_range(0, 9);
            d = (sel < 6) ? $urandom_range(1, 6) : ((sel < 8) ? $urandom_range(TO - 1, TO + 2) : 0);
            run_txn(vld, d, 2'($urandom), $urandom_range(0, 3), 1'b1);
        end

        // Reset in the middle of a wait: transaction is abandoned silently.
        set_req(1, 1'b1, 32'h0000_5000, 4'd5, 3'd2, 2'd1, 3'd4);
        drive_reqs(2'b10);
        tick();
        tick();
        tick();
        check("busy_before_reset", 64'(busy), 64'(1));
        #2;
        resetn = 1'b0;
        req_valid = 2'b00;
        #1;
        e_awaddr = '0; e_awlen = '0; e_awsize = '0; e_awburst = '0; e_awid = '0;
        e_araddr = '0; e_arlen = '0; e_arsize = '0; e_arburst = '0; e_arid = '0;
        prio_m = 0;
        check_all_zero("midreset");
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rsp_valid_post_reset", 64'(rsp_valid), 64'(0));
            check("busy_post_reset", 64'(busy), 64'(0));
        end
        rand_req(0);
        rand_req(1);
        grant_log.delete();
        run_txn(2'b11, 2, 2'b00, 0, 1'b0);
        check("grant_after_reset", 64'(grant_log[0]), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
